csr_trap_unit: RTL
==================

# csr_trap_unit

Parametrised machine/supervisor CSR file with trap sequencing for the scpu datapath, sitting at the MEM stage. Decodes SYSTEM instructions, performs CSRRW/RS/RC(I) read-modify-write, tracks privilege mode, takes ecall/illegal-instruction traps with optional delegation to S-mode, executes mret/sret, and issues a registered one-cycle PC redirect to the fetch stage.

## Interface
- XLEN, 64: CSR and PC width (32 or 64).
- HAS_SMODE, 1: 1 implements S-mode CSRs, sret and medeleg; 0 makes them illegal.
- RESET_MTVEC, 0: mtvec reset value.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  MEM-stage instruction valid.
- inst  in  32  MEM-stage instruction.
- pc  in  XLEN  PC of inst.
- rs1_data  in  XLEN  rs1 operand (register forms).
- stall  in  1  hold; no state update while high.
- csr_rdata  out  XLEN  old CSR value for rd, combinational.
- rd_write  out  1  CSR instruction retires with rd write, combinational.
- illegal  out  1  current inst traps as illegal, combinational.
- redirect_valid  out  1  one-cycle PC redirect, registered.
- redirect_pc  out  XLEN  redirect target, registered.
- priv_mode  out  2  current privilege (0 U, 1 S, 3 M).
- satp_out  out  XLEN  current satp.

## Operation
- CSRs: mstatus 300, medeleg 302, mtvec 305, mepc 341, mcause 342; sstatus 100, stvec 105, sepc 141, scause 142, satp 180 (S-set present only if HAS_SMODE).
- mstatus implements SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]; other bits read 0, ignore writes. sstatus is a view of SIE/SPIE/SPP only. mepc/sepc/mtvec/stvec bits [1:0] read 0. medeleg stores bits 2, 8, 9 only.
- Write data: CSRRW = src; CSRRS = old|src; CSRRC = old&~src; src = rs1_data or zero-extended uimm (inst[19:15]) for I-forms. RS/RC with rs1/uimm field 0 perform no write; RW with rd=x0 still writes.
- Illegal (cause 2): unimplemented address; addr[9:8] > priv_mode; write to addr[11:10]==2'b11 (so unimp c0001073 traps); mret with priv≠M; sret with priv==U or HAS_SMODE=0; funct3 0 SYSTEM other than ecall/mret/sret.
- ecall cause = 8/9/11 for U/S/M.
- Trap target: S if HAS_SMODE && priv≠M && medeleg[cause], else M.
- M-trap: mepc←pc, mcause←cause, MPIE←MIE, MIE←0, MPP←priv, priv←M, redirect to mtvec. S-trap: sepc←pc, scause←cause, SPIE←SIE, SIE←0, SPP←priv[0], priv←S, redirect to stvec.
- mret: priv←MPP, MIE←MPIE, MPIE←1, MPP←U, redirect to mepc. sret: priv←SPP, SIE←SPIE, SPIE←1, SPP←U, redirect to sepc.
- Trapping instructions write no CSR except trap state; rd_write=0.
- FSM RUN/REDIRECT: RUN→REDIRECT on accepted trap/mret/sret; REDIRECT→RUN unconditionally next cycle. stall does not hold REDIRECT.

## Timing
- Reset: priv_mode=3, all CSRs 0 except mtvec=RESET_MTVEC, state RUN, redirect_valid=0, redirect_pc=0, satp_out=0.
- Accept = inst_valid && !stall && state==RUN. CSR/priv updates on that edge; next-cycle reads see new value.
- redirect_valid high exactly the cycle after accept; redirect_pc target uses pre-update tvec/epc values.
- In REDIRECT, inst_valid is ignored (flushed slot); csr_rdata/rd_write/illegal forced 0.
- csr_rdata returns pre-write value; reads of illegal address return 0.
- Back-to-back CSR writes: second sees first's result with no bubble.
- rst_n low mid-REDIRECT: redirect_valid drops immediately (async), state RUN.

## Test plan
- Reset, csrrw x1,mtvec,x2 with x2=0x8000_0004 -> csr_rdata=RESET_MTVEC, next read mtvec=0x8000_0004 (bits[1:0]=0).
- In M, ecall at pc=0x100, mtvec=0x200 -> next cycle redirect_valid=1 for one cycle, redirect_pc=0x200, mepc=0x100, mcause=11, MPP=3, MIE=0.
- medeleg[8]=1, stvec=0x300, mret into U (MPP=0), ecall at pc=0x400 -> redirect_pc=0x300, scause=8, sepc=0x400, priv=1, SPP=0; sret -> redirect_pc=0x400, priv=0.
- In U, csrrs x1,mstatus,x0 -> illegal=1, mcause=2, priv=3; unimp c0001073 in M -> mcause=2.
- csrrs with rs1=x0 on satp while stall=1 toggles -> no state change; after stall drop, csrrc uimm=0 leaves satp unchanged, csrrw sets satp_out.
- Assert rst_n low during REDIRECT -> redirect_valid=0 same cycle, priv_mode=3 after release.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine/supervisor CSR file with trap sequencing for the scpu MEM stage.
// Performs CSR read-modify-write, ecall/illegal traps with S delegation, mret/sret and a registered PC redirect.
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter bit              HAS_SMODE   = 1'b1,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            stall,
  output logic [XLEN-1:0] csr_rdata,
  output logic            rd_write,
  output logic            illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] satp_out
);

  localparam logic [6:0]      OP_SYSTEM  = 7'b1110011;
  localparam logic [31:0]     INST_ECALL = 32'h0000_0073;
  localparam logic [31:0]     INST_MRET  = 32'h3020_0073;
  localparam logic [31:0]     INST_SRET  = 32'h1020_0073;
  localparam logic [1:0]      PRIV_U     = 2'd0;
  localparam logic [1:0]      PRIV_S     = 2'd1;
  localparam logic [1:0]      PRIV_M     = 2'd3;
  localparam logic [3:0]      CAUSE_ILL  = 4'd2;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

  state_t          state;
  logic [1:0]      priv;
  logic            st_sie, st_mie, st_spie, st_mpie, st_spp;
  logic [1:0]      st_mpp;
  logic [2:0]      medeleg;  // delegation bits for causes 9, 8, 2
  logic [XLEN-1:0] mtvec, mepc, mcause, stvec, sepc, scause, satp;

  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_field, rd_field;
  logic            is_system, is_csr, is_priv, is_ecall, is_mret, is_sret, csr_wr;
  logic            csr_impl, ill, live, trap, to_s, deleg_bit;
  logic [3:0]      cause;
  logic [XLEN-1:0] csr_old, src, wdata;

  // Field-wise legalisation keeps privilege restores from reaching a reserved mode
  function automatic logic [1:0] legal_mpp(input logic [1:0] v);
    if (v == 2'b10 || (v == PRIV_S && !HAS_SMODE)) return PRIV_U;
    return v;
  endfunction

  always_comb begin
    funct3    = inst[14:12];
    csr_addr  = inst[31:20];
    rs1_field = inst[19:15];
    rd_field  = inst[11:7];
    is_system = (inst[6:0] == OP_SYSTEM);
    is_csr    = is_system && (funct3[1:0] != 2'b00);
    is_priv   = is_system && (funct3 == 3'b000);
    is_ecall  = is_priv && (inst == INST_ECALL);
    is_mret   = is_priv && (inst == INST_MRET);
    is_sret   = is_priv && (inst == INST_SRET);
    csr_wr    = is_csr && ((funct3[1:0] == 2'b01) || (rs1_field != 5'd0));
  end

  // CSR read mux; csr_impl flags addresses this configuration provides
  always_comb begin
    csr_impl = 1'b1;
    csr_old  = '0;
    case (csr_addr)
      12'h300: csr_old = XLEN'({st_mpp, 2'b00, st_spp, st_mpie, 1'b0, st_spie, 1'b0,
                                st_mie, 1'b0, st_sie, 1'b0});
      12'h302: begin
        csr_impl = HAS_SMODE;
        csr_old  = XLEN'({medeleg[2:1], 5'b00000, medeleg[0], 2'b00});
      end
      12'h305: csr_old = mtvec;
      12'h341: csr_old = mepc;
      12'h342: csr_old = mcause;
      12'h100: begin
        csr_impl = HAS_SMODE;
        csr_old  = XLEN'({st_spp, 2'b00, st_spie, 3'b000, st_sie, 1'b0});
      end
      12'h105: begin csr_impl = HAS_SMODE; csr_old = stvec;  end
      12'h141: begin csr_impl = HAS_SMODE; csr_old = sepc;   end
      12'h142: begin csr_impl = HAS_SMODE; csr_old = scause; end
      12'h180: begin csr_impl = HAS_SMODE; csr_old = satp;   end
      default: csr_impl = 1'b0;
    endcase
  end

  always_comb begin
    ill = 1'b0;
    if (is_csr)
      ill = !csr_impl || (csr_addr[9:8] > priv) || (csr_wr && csr_addr[11:10] == 2'b11);
    else if (is_priv)
      ill = is_mret ? (priv != PRIV_M) :
            is_sret ? (!HAS_SMODE || priv == PRIV_U) : !is_ecall;
    else if (is_system)
      ill = 1'b1;

    trap  = ill || is_ecall;
    cause = ill ? CAUSE_ILL : (4'd8 | {2'b00, priv});
    case (cause)
      4'd2:    deleg_bit = medeleg[0];
      4'd8:    deleg_bit = medeleg[1];
      4'd9:    deleg_bit = medeleg[2];
      default: deleg_bit = 1'b0;
    endcase
    to_s = HAS_SMODE && (priv != PRIV_M) && deleg_bit;

    src = funct3[2] ? XLEN'(rs1_field) : rs1_data;
    case (funct3[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = csr_old | src;
      default: wdata = csr_old & ~src;
    endcase

    live      = inst_valid && (state == ST_RUN);
    illegal   = live && ill;
    rd_write  = live && is_csr && !ill && (rd_field != 5'd0);
    csr_rdata = (live && is_csr && !ill) ? csr_old : '0;
  end

  // Sequencer and architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      priv           <= PRIV_M;
      st_sie         <= 1'b0;
      st_mie         <= 1'b0;
      st_spie        <= 1'b0;
      st_mpie        <= 1'b0;
      st_spp         <= 1'b0;
      st_mpp         <= PRIV_U;
      medeleg        <= '0;
      mtvec          <= RESET_MTVEC & ALIGN_MASK;
      mepc           <= '0;
      mcause         <= '0;
      stvec          <= '0;
      sepc           <= '0;
      scause         <= '0;
      satp           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        ST_REDIRECT: state <= ST_RUN;
        ST_RUN: if (inst_valid && !stall) begin
          if (trap) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            if (to_s) begin
              sepc        <= pc & ALIGN_MASK;
              scause      <= XLEN'(cause);
              st_spie     <= st_sie;
              st_sie      <= 1'b0;
              st_spp      <= priv[0];
              priv        <= PRIV_S;
              redirect_pc <= stvec;
            end else begin
              mepc        <= pc & ALIGN_MASK;
              mcause      <= XLEN'(cause);
              st_mpie     <= st_mie;
              st_mie      <= 1'b0;
              st_mpp      <= priv;
              priv        <= PRIV_M;
              redirect_pc <= mtvec;
            end
          end else if (is_mret) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc;
            priv           <= st_mpp;
            st_mie         <= st_mpie;
            st_mpie        <= 1'b1;
            st_mpp         <= PRIV_U;
          end else if (is_sret) begin
            state          <= ST_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= sepc;
            priv           <= {1'b0, st_spp};
            st_sie         <= st_spie;
            st_spie        <= 1'b1;
            st_spp         <= 1'b0;
          end else if (csr_wr) begin
            case (csr_addr)
              12'h300: begin
                st_sie  <= wdata[1];
                st_mie  <= wdata[3];
                st_spie <= wdata[5];
                st_mpie <= wdata[7];
                st_spp  <= wdata[8];
                st_mpp  <= legal_mpp(wdata[12:11]);
              end
              12'h302: medeleg <= {wdata[9], wdata[8], wdata[2]};
              12'h305: mtvec   <= wdata & ALIGN_MASK;
              12'h341: mepc    <= wdata & ALIGN_MASK;
              12'h342: mcause  <= wdata;
              12'h100: begin
                st_sie  <= wdata[1];
                st_spie <= wdata[5];
                st_spp  <= wdata[8];
              end
              12'h105: stvec   <= wdata & ALIGN_MASK;
              12'h141: sepc    <= wdata & ALIGN_MASK;
              12'h142: scause  <= wdata;
              12'h180: satp    <= wdata;
              default: ;
            endcase
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign priv_mode = priv;
  assign satp_out  = satp;

endmodule
